// File: rtl/inst_fetch.sv
// Instruction-fetch front end: imem req/gnt/rvalid master with bounded in-flight
// requests, an instruction buffer toward decode, and stale-response dropping on redirect.
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MAX_OUTST  = 2,
    parameter int          IBUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);

    localparam int IW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int CW = $clog2(IBUF_DEPTH + 1);
    localparam int SW = $clog2(MAX_OUTST + IBUF_DEPTH + 1) + 1;
    localparam logic [IW-1:0] IB_LAST = IW'(IBUF_DEPTH - 1);
    localparam logic [PW-1:0] PD_LAST = PW'(MAX_OUTST - 1);

    logic          started_q, started_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [OW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] buf_cnt_q, buf_cnt_d;
    logic [IW-1:0] ib_wr_q, ib_wr_d, ib_rd_q, ib_rd_d;
    logic [PW-1:0] pd_wr_q, pd_wr_d, pd_rd_q, pd_rd_d;

    logic [31:0]   ib_instr_q [IBUF_DEPTH];
    logic [31:0]   ib_pc_q    [IBUF_DEPTH];
    logic [31:0]   pd_pc_q    [MAX_OUTST];

    logic          grant, rsp_keep, rsp_drop, pop;
    logic [SW-1:0] occupancy;

    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    function automatic logic [IW-1:0] ib_next(input logic [IW-1:0] p);
        return (p == IB_LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] pd_next(input logic [PW-1:0] p);
        return (p == PD_LAST) ? '0 : p + 1'b1;
    endfunction

    assign id_valid = (buf_cnt_q != '0);
    assign pop      = id_valid && id_ready && !redirect;
    assign rsp_drop = imem_rvalid && (drop_cnt_q != '0);
    assign rsp_keep = imem_rvalid && (drop_cnt_q == '0) && !redirect;

    // Live requests (not doomed to be dropped) plus buffered words must fit the buffer;
    // a same-cycle pop frees a slot, and without a grant this sum never grows, so req holds.
    assign occupancy = SW'(outst_q) - SW'(drop_cnt_q) + SW'(buf_cnt_q) - SW'(pop);
    assign imem_req  = started_q && !redirect
                    && (occupancy < SW'(IBUF_DEPTH))
                    && (outst_q < OW'(MAX_OUTST));
    assign imem_addr = fetch_pc_q;
    assign grant     = imem_req && imem_gnt;

    assign id_instr    = ib_instr_q[ib_rd_q];
    assign id_pc       = ib_pc_q[ib_rd_q];
    assign id_pc_plus4 = id_pc + 32'd4;

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        started_d  = 1'b1;
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q + OW'(grant) - OW'(imem_rvalid);
        drop_cnt_d = drop_cnt_q;
        buf_cnt_d  = buf_cnt_q;
        ib_wr_d    = ib_wr_q;
        ib_rd_d    = ib_rd_q;
        pd_wr_d    = pd_wr_q;
        pd_rd_d    = pd_rd_q;

        if (redirect) begin
            // Everything still outstanding after this cycle belongs to the old path.
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            drop_cnt_d = outst_q - OW'(imem_rvalid);
            buf_cnt_d  = '0;
            ib_wr_d    = '0;
            ib_rd_d    = '0;
            pd_wr_d    = '0;
            pd_rd_d    = '0;
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                pd_wr_d    = pd_next(pd_wr_q);
            end
            if (rsp_drop) drop_cnt_d = drop_cnt_q - 1'b1;
            if (rsp_keep) begin
                pd_rd_d = pd_next(pd_rd_q);
                ib_wr_d = ib_next(ib_wr_q);
            end
            if (pop) ib_rd_d = ib_next(ib_rd_q);
            buf_cnt_d = buf_cnt_q + CW'(rsp_keep) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started_q  <= 1'b0;
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            drop_cnt_q <= '0;
            buf_cnt_q  <= '0;
            ib_wr_q    <= '0;
            ib_rd_q    <= '0;
            pd_wr_q    <= '0;
            pd_rd_q    <= '0;
        end else begin
            started_q  <= started_d;
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            drop_cnt_q <= drop_cnt_d;
            buf_cnt_q  <= buf_cnt_d;
            ib_wr_q    <= ib_wr_d;
            ib_rd_q    <= ib_rd_d;
            pd_wr_q    <= pd_wr_d;
            pd_rd_q    <= pd_rd_d;
        end
    end

    // NOTE: storage arrays are not reset; the counters and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (rsp_keep) begin
            ib_instr_q[ib_wr_q] <= imem_rdata;
            ib_pc_q[ib_wr_q]    <= pd_pc_q[pd_rd_q];
        end
        if (grant) pd_pc_q[pd_wr_q] <= fetch_pc_q;
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: in-order memory responder, PC-stream scoreboard and protocol monitor.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          IBUF_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr, id_pc, id_pc_plus4;

    int checks = 0;
    int failures = 0;
    int grants = 0;
    int delivered = 0;

    logic [31:0] inflight [$];   // responder: addresses granted, returned in order
    logic [31:0] exp_q [$];      // scoreboard: PCs decode should see, in order

    logic        prev_req = 1'b0, prev_gnt = 1'b0, prev_redir = 1'b0;
    logic [31:0] prev_addr = '0, prev_target = '0, mon_exp = '0;

    inst_fetch #(.RESET_PC(RESET_PC), .MAX_OUTST(2), .IBUF_DEPTH(IBUF_DEPTH)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
        .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // A new sequential stream: target, target+4, ... (wraps mod 2^32).
    task automatic load_stream(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic drive_cycle(input bit redir, input logic [31:0] rpc, input bit rdy,
                               input int gnt_pct, input int rv_pct);
        @(negedge clk);
        redirect    = redir;
        redirect_pc = rpc;
        id_ready    = rdy;
        if (inflight.size() > 0 && int'($urandom_range(99)) < rv_pct) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(inflight.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        if (redir) load_stream(rpc & 32'hFFFF_FFFC);
        #1;
        if (imem_req && int'($urandom_range(99)) < gnt_pct) begin
            imem_gnt = 1'b1;
            inflight.push_back(imem_addr);
            grants++;
        end else begin
            imem_gnt = 1'b0;
        end
    endtask

    // Monitor: samples just before each rising edge, when all inputs are settled.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                prev_req = 1'b0; prev_gnt = 1'b0; prev_redir = 1'b0;
            end else begin
                if (redirect) check("req_in_redirect", {31'b0, imem_req}, 32'd0);
                if (prev_redir) begin
                    check("id_valid_after_redirect", {31'b0, id_valid}, 32'd0);
                    check("addr_after_redirect", imem_addr, prev_target);
                end
                if (imem_req) check("addr_aligned", {30'b0, imem_addr[1:0]}, 32'd0);
                if (prev_req && !prev_gnt && !redirect) begin
                    check("req_hold", {31'b0, imem_req}, 32'd1);
                    check("addr_hold", imem_addr, prev_addr);
                end
                if (id_valid && id_ready && !redirect) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_delivery: got pc %h expected none", id_pc);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("id_pc", id_pc, mon_exp);
                        check("id_pc_plus4", id_pc_plus4, mon_exp + 32'd4);
                        check("id_instr", id_instr, mem_word(mon_exp));
                    end
                    delivered++;
                end
                prev_req    = imem_req;
                prev_gnt    = imem_gnt;
                prev_addr   = imem_addr;
                prev_redir  = redirect;
                prev_target = redirect_pc & 32'hFFFF_FFFC;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g0, d0, since;
        bit seen;
        logic [31:0] tgt;

        // Reset state.
        #2;
        check("reset_req", {31'b0, imem_req}, 32'd0);
        check("reset_id_valid", {31'b0, id_valid}, 32'd0);
        check("reset_addr", imem_addr, RESET_PC);
        load_stream(RESET_PC);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Build two requests in flight, then reset asynchronously mid-cycle.
        repeat (4) drive_cycle(0, '0, 0, 100, 0);
        @(negedge clk);
        redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; id_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midreset_req", {31'b0, imem_req}, 32'd0);
        check("midreset_id_valid", {31'b0, id_valid}, 32'd0);
        check("midreset_addr", imem_addr, RESET_PC);
        inflight.delete();
        load_stream(RESET_PC);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            drive_cycle(0, '0, 1, 0, 0);
            if (imem_req) seen = 1'b1;
        end
        check("req_after_reset", {31'b0, seen}, 32'd1);
        check("first_addr_after_reset", imem_addr, RESET_PC);

        // Streaming: one word per cycle once the pipe fills.
        d0 = delivered;
        repeat (20) drive_cycle(0, '0, 1, 100, 100);
        check("stream_rate", {31'b0, (delivered - d0) >= 15}, 32'd1);

        // Backpressure: buffer fills to exactly IBUF_DEPTH and requests stop.
        drive_cycle(1, 32'h100, 1, 0, 100);
        g0 = grants;
        repeat (10) drive_cycle(0, '0, 0, 100, 100);
        check("stall_grants", 32'(grants - g0), 32'(IBUF_DEPTH));
        check("stall_req", {31'b0, imem_req}, 32'd0);
        check("stall_id_valid", {31'b0, id_valid}, 32'd1);
        repeat (10) drive_cycle(0, '0, 1, 100, 100);
        check("stall_resume", {31'b0, (grants - g0) > IBUF_DEPTH}, 32'd1);

        // Redirect with two requests in flight: both stale words dropped.
        drive_cycle(1, 32'h300, 1, 0, 100);
        repeat (4) drive_cycle(0, '0, 1, 0, 100);
        repeat (2) drive_cycle(0, '0, 1, 100, 0);
        check("two_in_flight", 32'(inflight.size()), 32'd2);
        drive_cycle(1, 32'h0AC, 1, 0, 0);
        d0 = delivered;
        repeat (12) drive_cycle(0, '0, 1, 100, 100);
        check("after_redirect_delivered", {31'b0, (delivered - d0) >= 2}, 32'd1);

        // Redirect coincident with rvalid and pop, misaligned target.
        drive_cycle(1, 32'h500, 1, 0, 100);
        repeat (4) drive_cycle(0, '0, 1, 100, 100);
        drive_cycle(1, 32'h0AE, 1, 0, 100);
        repeat (8) drive_cycle(0, '0, 1, 100, 100);

        // Back-to-back redirects: the later one wins.
        drive_cycle(1, 32'h1000, 1, 100, 100);
        drive_cycle(1, 32'h2000, 1, 100, 100);
        repeat (8) drive_cycle(0, '0, 1, 100, 100);

        // Wrap past the top of the address space.
        repeat (4) drive_cycle(0, '0, 1, 0, 100);
        drive_cycle(1, 32'hFFFF_FFFC, 1, 0, 100);
        drive_cycle(0, '0, 1, 100, 100);
        drive_cycle(0, '0, 1, 0, 100);
        check("wrap_addr", imem_addr, 32'h0000_0000);
        repeat (8) drive_cycle(0, '0, 1, 100, 100);

        // Randomized traffic.
        since = 0;
        for (int i = 0; i < 1500; i++) begin
            if (int'($urandom_range(99)) < 3 || since >= 50) begin
                tgt = $urandom;
                drive_cycle(1, tgt, int'($urandom_range(99)) < 70, 70, 60);
                since = 0;
            end else begin
                drive_cycle(0, $urandom, int'($urandom_range(99)) < 70, 70, 60);
                since++;
            end
        end
        drive_cycle(1, 32'h40, 1, 0, 100);
        d0 = delivered;
        repeat (20) drive_cycle(0, '0, 1, 100, 100);
        check("final_drain", {31'b0, (delivered - d0) >= 15}, 32'd1);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
